// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz raster timing constants and window helper.
// Other VGA blocks import this for their visible-window comparisons.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_CLK_DIV     = 4;
  localparam int unsigned VGA_H_TOTAL     = 800;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_VIS_START = 144;
  localparam int unsigned VGA_H_VIS_END   = 783;
  localparam int unsigned VGA_V_TOTAL     = 525;
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_VIS_START = 35;
  localparam int unsigned VGA_V_VIS_END   = 514;

  typedef logic [CNT_W-1:0] cnt_t;

  // Inclusive range test on raster coordinates.
  function automatic logic in_window(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// mod_counter: wrap-at-N counter with enable.
// Ports:
//   clk, reset_n       - clock, async active-low reset (count -> 0)
//   en                 - advance on this clk edge
//   count              - registered count, 0..N-1
//   count_next_c       - value count takes on the next edge (combinational)
//   wrap_c             - high when the next edge wraps N-1 -> 0 (combinational)
module mod_counter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next_c,
  output logic         wrap_c
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Next-state: hold, increment, or wrap to zero at N-1.
  always_comb begin
    wrap_c       = 1'b0;
    count_next_c = count;
    wrap_c       = en && (count == LAST);
    if (wrap_c) begin
      count_next_c = '0;
    end else if (en) begin
      count_next_c = count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator. Divides clk to a pixel
// enable, runs horizontal/vertical counters and decodes sync/visible flags.
// Ports:
//   clk, reset_n   - board clock, async active-low reset
//   pix_en         - one-clk pulse every CLK_DIV clocks; counters step on it
//   hCount, vCount - current column / line
//   hSync, vSync   - active-low syncs
//   bright         - inside the visible window
//   line_start     - one-clk pulse after hCount wraps to 0
//   frame_start    - one-clk pulse after both counters wrap to 0
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_VIS_START = VGA_H_VIS_START,
  parameter int unsigned H_VIS_END   = VGA_H_VIS_END,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_VIS_START = VGA_V_VIS_START,
  parameter int unsigned V_VIS_END   = VGA_V_VIS_END
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             pix_en,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next_c;
  logic             div_wrap_c;
  logic             unused_div;
  logic [CNT_W-1:0] h_next_c;
  logic [CNT_W-1:0] v_next_c;
  logic             h_wrap_c;
  logic             v_wrap_c;
  logic             pix_en_next_c;
  logic             hsync_next_c;
  logic             vsync_next_c;
  logic             bright_next_c;

  // Prescaler; its wrap edge is the edge on which pix_en is high.
  mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (1'b1),
    .count        (div_cnt),
    .count_next_c (div_next_c),
    .wrap_c       (div_wrap_c)
  );

  // pix_en is regenerated from the next prescaler value, so the raw count is not needed.
  assign unused_div = ^div_cnt;

  mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (div_wrap_c),
    .count        (hCount),
    .count_next_c (h_next_c),
    .wrap_c       (h_wrap_c)
  );

  mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (h_wrap_c),
    .count        (vCount),
    .count_next_c (v_next_c),
    .wrap_c       (v_wrap_c)
  );

  // Decode from next-state counters so the registered flags line up with hCount/vCount.
  always_comb begin
    pix_en_next_c = 1'b0;
    hsync_next_c  = 1'b0;
    vsync_next_c  = 1'b0;
    bright_next_c = 1'b0;
    pix_en_next_c = (div_next_c == DIV_W'(CLK_DIV - 1));
    hsync_next_c  = (h_next_c >= CNT_W'(H_SYNC));
    vsync_next_c  = (v_next_c >= CNT_W'(V_SYNC));
    bright_next_c = in_window(h_next_c, CNT_W'(H_VIS_START), CNT_W'(H_VIS_END)) &&
                    in_window(v_next_c, CNT_W'(V_VIS_START), CNT_W'(V_VIS_END));
  end

  // v_wrap_c is only ever set on an h-wrap edge, so it marks a full frame wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_en      <= 1'b0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= pix_en_next_c;
      hSync       <= hsync_next_c;
      vSync       <= vsync_next_c;
      bright      <= bright_next_c;
      line_start  <= h_wrap_c;
      frame_start <= v_wrap_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default instance (directed scoreboard), a CLK_DIV=2
// instance with 640x480 geometry, and a CLK_DIV=2 instance with a tiny raster
// so full frames and a mid-frame reset fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  logic       a_pix, a_hs, a_vs, a_br, a_ls, a_fs;
  logic [9:0] a_h, a_v;
  logic       b_pix, b_hs, b_vs, b_br, b_ls, b_fs;
  logic [9:0] b_h, b_v;
  logic       c_pix, c_hs, c_vs, c_br, c_ls, c_fs;
  logic [9:0] c_h, c_v;

  vga_timing_gen u_dut (
    .clk(clk), .reset_n(rst_a), .pix_en(a_pix), .hCount(a_h), .vCount(a_v),
    .hSync(a_hs), .vSync(a_vs), .bright(a_br), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .reset_n(rst_b), .pix_en(b_pix), .hCount(b_h), .vCount(b_v),
    .hSync(b_hs), .vSync(b_vs), .bright(b_br), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(16), .H_SYNC(3), .H_VIS_START(4), .H_VIS_END(13),
    .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8)
  ) u_small (
    .clk(clk), .reset_n(rst_c), .pix_en(c_pix), .hCount(c_h), .vCount(c_v),
    .hSync(c_hs), .vSync(c_vs), .bright(c_br), .line_start(c_ls), .frame_start(c_fs)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard for u_dut: expected {pix_en,hCount,vCount,hSync,vSync,bright,line_start,frame_start}
  // keyed by the number of clk edges since reset release.
  typedef struct {
    int unsigned edge_n;
    logic [25:0] vec;
    string       tag;
  } exp_t;

  exp_t aq[$];
  int unsigned a_edge = 0;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) a_edge <= 0;
    else        a_edge <= a_edge + 1;
  end

  task automatic push_a(input string tag, input int unsigned e, input logic p,
                        input int unsigned h, input int unsigned v, input logic hs,
                        input logic vs, input logic br, input logic ls, input logic fs);
    exp_t x;
    x.tag    = tag;
    x.edge_n = e;
    x.vec    = {p, 10'(h), 10'(v), hs, vs, br, ls, fs};
    aq.push_back(x);
  endtask

  initial begin
    exp_t cur;
    logic [25:0] act;
    forever begin
      @(negedge clk);
      while (aq.size() > 0 && aq[0].edge_n == a_edge) begin
        cur = aq.pop_front();
        act = {a_pix, a_h, a_v, a_hs, a_vs, a_br, a_ls, a_fs};
        check(cur.tag, 32'(act), 32'(cur.vec));
      end
    end
  end

  task automatic run_a();
    int unsigned hs_low = 0, nls = 0, ls1 = 0, ls2 = 0;
    for (int unsigned e = 1; e <= 6800; e++) begin
      @(negedge clk);
      if (a_pix && e <= 3200 && !a_hs) hs_low++;
      if (a_ls) begin
        nls++;
        if (nls == 1) ls1 = e;
        else if (nls == 2) ls2 = e;
      end
    end
    check("a_hsync_low_px", hs_low, 96);
    check("a_line_start_cnt", nls, 2);
    check("a_line_start_first", ls1, 3200);
    check("a_line_period", ls2 - ls1, 3200);
  endtask

  task automatic run_b();
    int unsigned npix = 0, pix1 = 0, pix2 = 0, nls = 0, ls1 = 0, ls2 = 0;
    int unsigned hs_low = 0, br_early = 0, br35 = 0, br_first = 1023, br_last = 0;
    for (int unsigned e = 1; e <= 57600; e++) begin
      @(negedge clk);
      if (b_pix) begin
        npix++;
        if (npix == 1) pix1 = e;
        else if (npix == 2) pix2 = e;
        if (b_v == 10'd0 && !b_hs) hs_low++;
        if (b_br && b_v < 10'd35) br_early++;
        if (b_br && b_v == 10'd35) begin
          br35++;
          if (32'(b_h) < br_first) br_first = 32'(b_h);
          if (32'(b_h) > br_last)  br_last  = 32'(b_h);
        end
      end
      if (b_ls) begin
        nls++;
        if (nls == 1) ls1 = e;
        else if (nls == 2) ls2 = e;
      end
    end
    check("b_first_pix_en", pix1, 1);
    check("b_pix_en_period", pix2 - pix1, 2);
    check("b_line_start_first", ls1, 1600);
    check("b_line_period", ls2 - ls1, 1600);
    check("b_hsync_low_px", hs_low, 96);
    check("b_bright_above_vis", br_early, 0);
    check("b_bright_px_line35", br35, 640);
    check("b_bright_first_col", br_first, 144);
    check("b_bright_last_col", br_last, 783);
  endtask

  task automatic run_c();
    int unsigned vs_low = 0, vs_bad = 0, br_cnt = 0, br_bad = 0;
    int unsigned nfs = 0, fs1 = 0, fs2 = 0, fs_no_ls = 0, fs_after = 0;
    int unsigned v319 = 0, v320 = 99, h320 = 99, h1 = 99, v1 = 99, h3 = 99;
    logic        p1 = 1'b0;
    logic        found = 1'b0;
    for (int unsigned e = 1; e <= 660; e++) begin
      @(negedge clk);
      if (c_pix && e <= 640) begin
        if (!c_vs) vs_low++;
        if ((!c_vs) != (c_v < 10'd2)) vs_bad++;
        if (c_br) br_cnt++;
        if (c_br && (c_v < 10'd3 || c_v > 10'd8)) br_bad++;
      end
      if (c_fs) begin
        nfs++;
        if (nfs == 1) fs1 = e;
        else if (nfs == 2) fs2 = e;
        if (!c_ls) fs_no_ls++;
      end
      if (e == 319) v319 = 32'(c_v);
      if (e == 320) begin
        v320 = 32'(c_v);
        h320 = 32'(c_h);
      end
    end
    check("c_vsync_low_px", vs_low, 64);
    check("c_vsync_decode", vs_bad, 0);
    check("c_bright_px", br_cnt, 120);
    check("c_bright_outside", br_bad, 0);
    check("c_frame_start_cnt", nfs, 2);
    check("c_frame_start_first", fs1, 320);
    check("c_frame_period", fs2 - fs1, 320);
    check("c_frame_without_line", fs_no_ls, 0);
    check("c_vcount_last", v319, 9);
    check("c_vcount_wrap", v320, 0);
    check("c_hcount_wrap", h320, 0);

    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (c_h == 10'd8 && c_v == 10'd6) found = 1'b1;
    end
    check("c_reached_v6_h8", 32'(found), 1);
    check("c_bright_before_reset", 32'(c_br), 1);
    #1 rst_c = 1'b0;
    #1;
    check("c_rst_hcount", 32'(c_h), 0);
    check("c_rst_vcount", 32'(c_v), 0);
    check("c_rst_flags", 32'({c_pix, c_hs, c_vs, c_br, c_ls, c_fs}), 0);
    repeat (3) @(negedge clk);
    #2 rst_c = 1'b1;
    for (int unsigned e = 1; e <= 330; e++) begin
      @(negedge clk);
      if (e == 1) begin
        h1 = 32'(c_h);
        v1 = 32'(c_v);
        p1 = c_pix;
      end
      if (e == 3) h3 = 32'(c_h);
      if (c_fs && fs_after == 0) fs_after = e;
    end
    check("c_restart_h", h1, 0);
    check("c_restart_v", v1, 0);
    check("c_restart_pix_en", 32'(p1), 1);
    check("c_restart_h_step", h3, 1);
    check("c_restart_frame_first", fs_after, 320);
  endtask

  initial begin
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (10) @(posedge clk);
    push_a("reset_values", 0,    0, 0,   0, 0, 0, 0, 0, 0);
    push_a("edge1",        1,    0, 0,   0, 0, 0, 0, 0, 0);
    push_a("edge2",        2,    0, 0,   0, 0, 0, 0, 0, 0);
    push_a("first_pix_en", 3,    1, 0,   0, 0, 0, 0, 0, 0);
    push_a("first_h_inc",  4,    0, 1,   0, 0, 0, 0, 0, 0);
    push_a("hsync_last",   383,  1, 95,  0, 0, 0, 0, 0, 0);
    push_a("hsync_rise",   384,  0, 96,  0, 1, 0, 0, 0, 0);
    push_a("h_last_col",   3199, 1, 799, 0, 1, 0, 0, 0, 0);
    push_a("h_wrap",       3200, 0, 0,   1, 0, 0, 0, 1, 0);
    push_a("line_pulse_end", 3201, 0, 0, 1, 0, 0, 0, 0, 0);
    push_a("vsync_rise",   6400, 0, 0,   2, 0, 1, 0, 1, 0);
    push_a("line2_hsync",  6784, 0, 96,  2, 1, 1, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    fork
      run_a();
      run_b();
      run_c();
    join
    check("a_scoreboard_drained", 32'(aq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA path. It divides the 100 MHz board clock to a 25 MHz pixel enable and runs the horizontal and vertical counters. From those counters it drives `hSync`, `vSync`, `bright`, `hCount` and `vCount`. It sits upstream of the pixel-colour logic, which paints `rgb` from `hCount`/`vCount`/`bright`. It also supplies frame and line strobes that the game logic uses for per-frame object updates.

## Interface
Parameters:
- `CLK_DIV`, 4: board clocks per pixel; must be ≥ 2.
- `H_TOTAL`, 800: clocks per line in pixels.
- `H_SYNC`, 96: hSync low width.
- `H_VIS_START`, 144: first visible column.
- `H_VIS_END`, 783: last visible column, inclusive.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vSync low width in lines.
- `V_VIS_START`, 35: first visible line.
- `V_VIS_END`, 514: last visible line, inclusive.

Ports:
- `clk` in 1: 100 MHz board clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pix_en` out 1: one-`clk` pulse every `CLK_DIV` clocks; counters advance on it.
- `hCount` out 10: column, 0..`H_TOTAL`-1.
- `vCount` out 10: line, 0..`V_TOTAL`-1.
- `hSync` out 1: active-low horizontal sync.
- `vSync` out 1: active-low vertical sync.
- `bright` out 1: high inside the visible window.
- `line_start` out 1: one-`clk` pulse when `hCount` wraps to 0.
- `frame_start` out 1: one-`clk` pulse when `hCount` and `vCount` both wrap to 0.

## Operation
- Prescaler `div_cnt` counts 0..`CLK_DIV`-1 and wraps. `pix_en` is asserted while `div_cnt` = `CLK_DIV`-1.
- On a `clk` edge with `pix_en` high:
  - `hCount` increments.
  - At `H_TOTAL`-1, `hCount` wraps to 0 and `vCount` increments.
  - `vCount` at `V_TOTAL`-1 wraps to 0 on that same edge.
- Counters hold when `pix_en` is low.
- `hSync` = 0 iff `hCount` < `H_SYNC`; otherwise 1.
- `vSync` = 0 iff `vCount` < `V_SYNC`; otherwise 1.
- `bright` = 1 iff `H_VIS_START` ≤ `hCount` ≤ `H_VIS_END` and `V_VIS_START` ≤ `vCount` ≤ `V_VIS_END`.
- `line_start` is high for the single `clk` cycle following an edge that wrapped `hCount` to 0.
- `frame_start` is the same, for a wrap of both counters to 0. Every `frame_start` coincides with a `line_start`.
- All outputs are registers. Sync/bright decode is computed from next-state counter values, so each output is consistent with the `hCount`/`vCount` it is presented alongside, with no extra lag.
- Arithmetic is unsigned, 10-bit. Comparisons are inclusive exactly as stated. No counter ever exceeds its TOTAL-1.

## Timing
- Reset (`reset_n` low, asynchronous) forces:
  - `div_cnt` = 0, `hCount` = 0, `vCount` = 0.
  - `pix_en` = 0, `hSync` = 0, `vSync` = 0, `bright` = 0.
  - `line_start` = 0, `frame_start` = 0.
- Release is synchronous in effect. The first `pix_en` comes `CLK_DIV` clocks after the first edge with `reset_n` high.
- After reset, the first `hCount` increment (0→1) happens on the first `pix_en` edge.
- Reset asserted mid-frame aborts the raster immediately. No `frame_start` is emitted for the aborted frame.
- Line period is `H_TOTAL`×`CLK_DIV` = 3200 clk. Frame period is 3200×525 = 1,680,000 clk.
- Simultaneous h-wrap and v-wrap: both counters become 0 on one edge. `line_start` and `frame_start` pulse together on the next cycle.

## Structure
- Shared package `vga_timing_pkg` holds the 640x480 timing constants: totals, sync widths and visible bounds. Other VGA blocks use it for their visible-window comparisons.
- One natural sub-module, `mod_counter`: a parameterised wrap-at-N counter with enable and a wrap flag. It is instantiated for the prescaler, the horizontal counter and the vertical counter.

## Test plan
- Reset and release:
  - Hold `reset_n` low for 10 clk.
  - Expect every output at its reset value.
  - Release, then expect the first `pix_en` on clock 4 and `hCount` = 1 after the 4th edge.
- Horizontal sweep: over one line, expect `hSync` low for exactly 96 pixels (hCount 0..95), `bright` high for hCount 144..783 on a visible line, and `hCount` 799→0 with `line_start` pulsed once.
- Vertical sweep: over a full frame, expect `vSync` low for vCount 0..1, `bright` never high on vCount < 35 or > 514, `vCount` 524→0, and exactly one `frame_start`.
- Period check: measure `frame_start` spacing as 1,680,000 clk and `line_start` spacing as 3200 clk.
- Mid-frame reset: assert `reset_n` low at vCount = 300, hCount = 400. Expect all outputs to clear asynchronously, before the next clk edge. After release, expect the counters to restart from 0,0.
- Parameter override: build with `CLK_DIV` = 2. Expect a `pix_en` period of 2 clk and a line period of 1600 clk, with sync/bright pixel positions unchanged.
